instruction_fetch_unit: RTL and testbench

- Fetch stage (IF plus the IF/ID pipeline register) of the pipelined LEGv8 CPU; the requester side of the instruction memory read port.
- Holds the PC and drives the 64-bit word address to instruction memory, which returns a 32-bit word combinationally in the same cycle.
- Captures that word into IF/ID; handles decode stall, branch/BL redirect from MEM, halt and misalignment fault.
- Injects the canonical NOP into IF/ID on any bubble.

---
 rtl/instruction_fetch_unit_if.sv | 25 ++
 rtl/instruction_fetch_unit.sv | 106 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read port plus the IF/ID and control signals of the fetch stage.
interface instruction_fetch_unit_if #(parameter int COUNT_W = 32);
  logic [63:0]        imem_addr;
  logic [31:0]        imem_data;
  logic               stall;
  logic               redirect;
  logic [63:0]        redirect_target;
  logic               halt_req;
  logic [31:0]        if_instr;
  logic [63:0]        if_pc;
  logic               if_valid;
  logic               flush;
  logic               fault;
  logic [COUNT_W-1:0] fetch_count;

  modport master (
    output imem_addr, if_instr, if_pc, if_valid, flush, fault, fetch_count,
    input  imem_data, stall, redirect, redirect_target, halt_req
  );

  modport slave (
    input  imem_addr, if_instr, if_pc, if_valid, flush, fault, fetch_count,
    output imem_data, stall, redirect, redirect_target, halt_req
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// LEGv8 fetch stage: PC, IF/ID register, stall/redirect/halt handling and
// a sticky misaligned-target fault.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [31:0] NOP_WORD = 32'h8B1F03FF,
  parameter int          COUNT_W  = 32
) (
  input  logic                    CLK,
  input  logic                    Reset,
  instruction_fetch_unit_if.master bus
);
  typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;

  state_t             state, state_nxt;
  logic [63:0]        pc, pc_nxt;
  logic [31:0]        instr, instr_nxt;
  logic [63:0]        ifpc, ifpc_nxt;
  logic               vld, vld_nxt;
  logic               flt, flt_nxt;
  logic [COUNT_W-1:0] cnt, cnt_nxt;
  logic               aligned, take;

  assign aligned = (bus.redirect_target[1:0] == 2'b00);
  // A redirect is accepted only outside FAULT and never while Reset is high.
  assign take    = !Reset && bus.redirect && aligned && (state != FAULT);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= RUN;
      pc    <= RESET_PC;
      instr <= NOP_WORD;
      ifpc  <= 64'h0;
      vld   <= 1'b0;
      flt   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      instr <= instr_nxt;
      ifpc  <= ifpc_nxt;
      vld   <= vld_nxt;
      flt   <= flt_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr;
    ifpc_nxt  = ifpc;
    vld_nxt   = vld;
    flt_nxt   = flt;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (bus.redirect) begin
          pc_nxt    = bus.redirect_target;
          instr_nxt = NOP_WORD;
          ifpc_nxt  = pc;
          vld_nxt   = 1'b0;
          if (!aligned) begin
            flt_nxt   = 1'b1;
            state_nxt = FAULT;
          end
        end else if (bus.stall) begin
          // hold everything
        end else if (bus.halt_req) begin
          instr_nxt = NOP_WORD;
          ifpc_nxt  = pc;
          vld_nxt   = 1'b0;
          state_nxt = HALT;
        end else begin
          instr_nxt = bus.imem_data;
          ifpc_nxt  = pc;
          vld_nxt   = 1'b1;
          pc_nxt    = pc + 64'd4;
          cnt_nxt   = cnt + COUNT_W'(1);
        end
      end
      HALT: begin
        instr_nxt = NOP_WORD;
        vld_nxt   = 1'b0;
        if (bus.redirect && aligned) begin
          pc_nxt    = bus.redirect_target;
          ifpc_nxt  = pc;
          state_nxt = RUN;
        end
      end
      FAULT: begin
        instr_nxt = NOP_WORD;
        vld_nxt   = 1'b0;
        flt_nxt   = 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign bus.imem_addr   = pc;
  assign bus.if_instr    = instr;
  assign bus.if_pc       = ifpc;
  assign bus.if_valid    = vld;
  assign bus.flush       = take;
  assign bus.fault       = flt;
  assign bus.fetch_count = cnt;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vector table, randomized run
// against a behavioural model, and a narrow-counter wrap check.
module tb_instruction_fetch_unit;
  localparam logic [31:0] NOP = 32'h8B1F03FF;

  logic CLK = 1'b0;
  logic Reset, rst2;
  int   n_cmp = 0, n_bad = 0;

  always #5 CLK = ~CLK;

  instruction_fetch_unit_if #(.COUNT_W(32)) bus ();
  instruction_fetch_unit_if #(.COUNT_W(3))  b2 ();

  instruction_fetch_unit #(.COUNT_W(32)) dut  (.CLK(CLK), .Reset(Reset), .bus(bus));
  instruction_fetch_unit #(.COUNT_W(3))  dut2 (.CLK(CLK), .Reset(rst2),  .bus(b2));

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h0:   return 32'hF84083EA;
      64'h4:   return 32'hF84103EB;
      64'h8:   return 32'hF84003E9;
      64'hC:   return 32'hF84183EC;
      default: return a[31:0] ^ a[63:32] ^ 32'h5A5A_0000;
    endcase
  endfunction

  assign bus.imem_data = mem_word(bus.imem_addr);
  assign b2.imem_data  = mem_word(b2.imem_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0=running, 1=halted, 2=faulted
  int          m_mode;
  logic [63:0] m_pc, m_ifpc;
  logic [31:0] m_instr, m_cnt;
  logic        m_valid, m_fault, m_ifpc_ok, m_flush;

  task automatic model_step(input logic rst, stall, redir, halt, input logic [63:0] tgt);
    bit ok = (tgt % 4 == 0);
    m_flush = !rst && redir && ok && (m_mode != 2);
    if (rst) begin
      m_mode = 0; m_pc = 64'h0; m_ifpc = 64'h0; m_ifpc_ok = 1;
      m_instr = NOP; m_valid = 0; m_fault = 0; m_cnt = 0;
    end else if (m_mode == 0) begin
      if (redir) begin
        m_ifpc = m_pc; m_ifpc_ok = 1; m_pc = tgt; m_instr = NOP; m_valid = 0;
        if (!ok) begin m_fault = 1; m_mode = 2; m_ifpc_ok = 0; end
      end else if (!stall) begin
        if (halt) begin
          m_instr = NOP; m_valid = 0; m_ifpc_ok = 0; m_mode = 1;
        end else begin
          m_instr = mem_word(m_pc); m_ifpc = m_pc; m_ifpc_ok = 1;
          m_valid = 1; m_pc = m_pc + 64'd4; m_cnt = m_cnt + 1;
        end
      end
    end else if (m_mode == 1 && redir && ok) begin
      m_pc = tgt; m_mode = 0; m_ifpc_ok = 0;
    end
  endtask

  logic pre_flush;

  task automatic cyc(input logic rst, stall, redir, halt, input logic [63:0] tgt);
    @(negedge CLK);
    Reset = rst; bus.stall = stall; bus.redirect = redir;
    bus.halt_req = halt; bus.redirect_target = tgt;
    #1 pre_flush = bus.flush;
    @(posedge CLK);
    model_step(rst, stall, redir, halt, tgt);
    #1;
  endtask

  typedef struct {
    logic rst, stall, redir, halt;
    logic [63:0] tgt;
    logic flush;
    logic [63:0] addr;
    logic valid;
    logic ic;
    logic [63:0] ifpc;
    logic [31:0] instr;
    logic fault;
    logic [31:0] cnt;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(logic rst, stall, redir, halt, logic [63:0] tgt, logic fl,
                             logic [63:0] addr, logic valid, logic ic, logic [63:0] ifpc,
                             logic [31:0] instr, logic fault, logic [31:0] cnt);
    vec_t r;
    r.rst = rst; r.stall = stall; r.redir = redir; r.halt = halt; r.tgt = tgt;
    r.flush = fl; r.addr = addr; r.valid = valid; r.ic = ic; r.ifpc = ifpc;
    r.instr = instr; r.fault = fault; r.cnt = cnt;
    return r;
  endfunction

  initial begin
    logic [63:0] top;
    top = 64'hFFFF_FFFF_FFFF_FFFC;
    Reset = 1; rst2 = 1;
    bus.stall = 0; bus.redirect = 0; bus.halt_req = 0; bus.redirect_target = 0;
    b2.stall = 0; b2.redirect = 0; b2.halt_req = 0; b2.redirect_target = 0;
    m_mode = 0; m_pc = 0; m_ifpc = 0; m_instr = NOP; m_cnt = 0;
    m_valid = 0; m_fault = 0; m_ifpc_ok = 0; m_flush = 0;

    //          rst st rd hl tgt      fl addr     v  ic ifpc    instr               flt cnt
    tv.push_back(v(1, 0, 0, 0, 0,     0, 64'h0,   0, 1, 64'h0,  NOP,                0, 0));
    tv.push_back(v(0, 0, 0, 0, 0,     0, 64'h4,   1, 1, 64'h0,  32'hF84083EA,       0, 1));
    tv.push_back(v(0, 0, 0, 0, 0,     0, 64'h8,   1, 1, 64'h4,  32'hF84103EB,       0, 2));
    tv.push_back(v(0, 1, 0, 0, 0,     0, 64'h8,   1, 1, 64'h4,  32'hF84103EB,       0, 2));
    tv.push_back(v(0, 1, 0, 0, 0,     0, 64'h8,   1, 1, 64'h4,  32'hF84103EB,       0, 2));
    tv.push_back(v(0, 1, 0, 0, 0,     0, 64'h8,   1, 1, 64'h4,  32'hF84103EB,       0, 2));
    tv.push_back(v(0, 0, 0, 0, 0,     0, 64'hC,   1, 1, 64'h8,  32'hF84003E9,       0, 3));
    tv.push_back(v(0, 0, 0, 0, 0,     0, 64'h10,  1, 1, 64'hC,  32'hF84183EC,       0, 4));
    tv.push_back(v(0, 1, 1, 0, 64'h28, 1, 64'h28, 0, 1, 64'h10, NOP,                0, 4));
    tv.push_back(v(0, 0, 0, 0, 0,     0, 64'h2C,  1, 1, 64'h28, mem_word(64'h28),   0, 5));
    tv.push_back(v(0, 0, 1, 0, 64'h64, 1, 64'h64, 0, 1, 64'h2C, NOP,                0, 5));
    tv.push_back(v(0, 0, 0, 1, 0,     0, 64'h64,  0, 0, 64'h0,  NOP,                0, 5));
    tv.push_back(v(0, 0, 0, 0, 0,     0, 64'h64,  0, 0, 64'h0,  NOP,                0, 5));
    tv.push_back(v(0, 1, 0, 0, 0,     0, 64'h64,  0, 0, 64'h0,  NOP,                0, 5));
    tv.push_back(v(0, 0, 1, 0, 64'h68, 1, 64'h68, 0, 0, 64'h0,  NOP,                0, 5));
    tv.push_back(v(0, 0, 0, 0, 0,     0, 64'h6C,  1, 1, 64'h68, mem_word(64'h68),   0, 6));
    tv.push_back(v(0, 0, 1, 0, 64'h2A, 0, 64'h2A, 0, 0, 64'h0,  NOP,                1, 6));
    tv.push_back(v(0, 0, 1, 0, 64'h40, 0, 64'h2A, 0, 0, 64'h0,  NOP,                1, 6));
    tv.push_back(v(0, 1, 0, 0, 0,     0, 64'h2A,  0, 0, 64'h0,  NOP,                1, 6));
    tv.push_back(v(0, 0, 0, 0, 0,     0, 64'h2A,  0, 0, 64'h0,  NOP,                1, 6));
    tv.push_back(v(1, 0, 0, 0, 0,     0, 64'h0,   0, 1, 64'h0,  NOP,                0, 0));
    tv.push_back(v(0, 0, 1, 0, top,   1, top,     0, 1, 64'h0,  NOP,                0, 0));
    tv.push_back(v(0, 0, 0, 0, 0,     0, 64'h0,   1, 1, top,    mem_word(top),      0, 1));
    tv.push_back(v(0, 1, 0, 0, 0,     0, 64'h0,   1, 1, top,    mem_word(top),      0, 1));
    tv.push_back(v(1, 1, 0, 0, 0,     0, 64'h0,   0, 1, 64'h0,  NOP,                0, 0));
    tv.push_back(v(1, 0, 1, 0, 64'h40, 0, 64'h0,  0, 1, 64'h0,  NOP,                0, 0));
    tv.push_back(v(0, 0, 0, 0, 0,     0, 64'h4,   1, 1, 64'h0,  32'hF84083EA,       0, 1));

    foreach (tv[i]) begin
      cyc(tv[i].rst, tv[i].stall, tv[i].redir, tv[i].halt, tv[i].tgt);
      chk($sformatf("vec%0d flush", i), 64'(pre_flush), 64'(tv[i].flush));
      chk($sformatf("vec%0d imem_addr", i), bus.imem_addr, tv[i].addr);
      chk($sformatf("vec%0d if_valid", i), 64'(bus.if_valid), 64'(tv[i].valid));
      chk($sformatf("vec%0d if_instr", i), 64'(bus.if_instr), 64'(tv[i].instr));
      chk($sformatf("vec%0d fault", i), 64'(bus.fault), 64'(tv[i].fault));
      chk($sformatf("vec%0d fetch_count", i), 64'(bus.fetch_count), 64'(tv[i].cnt));
      if (tv[i].ic) chk($sformatf("vec%0d if_pc", i), bus.if_pc, tv[i].ifpc);
    end

    // Randomized run against the model
    for (int k = 0; k < 3000; k++) begin
      logic r_rst, r_st, r_rd, r_hl;
      logic [63:0] t;
      int sel;
      r_rst = ($urandom_range(0, 99) < 2);
      r_st  = ($urandom_range(0, 3) == 0);
      r_rd  = ($urandom_range(0, 7) == 0);
      r_hl  = ($urandom_range(0, 15) == 0);
      sel   = $urandom_range(0, 9);
      if (sel == 0)      t = {54'($urandom_range(0, 255)), 8'h0, 2'($urandom_range(1, 3))};
      else if (sel == 1) t = 64'hFFFF_FFFF_FFFF_FFF0 + 64'(4 * $urandom_range(0, 3));
      else               t = 64'(4 * $urandom_range(0, 255));
      cyc(r_rst, r_st, r_rd, r_hl, t);
      chk("rnd flush", 64'(pre_flush), 64'(m_flush));
      chk("rnd imem_addr", bus.imem_addr, m_pc);
      chk("rnd if_valid", 64'(bus.if_valid), 64'(m_valid));
      chk("rnd if_instr", 64'(bus.if_instr), 64'(m_instr));
      chk("rnd fault", 64'(bus.fault), 64'(m_fault));
      chk("rnd fetch_count", 64'(bus.fetch_count), 64'(m_cnt));
      if (m_ifpc_ok) chk("rnd if_pc", bus.if_pc, m_ifpc);
    end

    // Narrow counter wraps at 2^COUNT_W
    @(negedge CLK); rst2 = 1;
    @(posedge CLK); #1 chk("wrap reset count", 64'(b2.fetch_count), 64'h0);
    @(negedge CLK); rst2 = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge CLK); #1;
      chk($sformatf("wrap count %0d", k), 64'(b2.fetch_count), 64'(k % 8));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
